// File: rtl/calc_pkg.sv
// Shared key codes, operation codes and FSM state encoding for the hex calculator sequencer.
package calc_pkg;

   localparam logic [4:0] KEY_ENTER    = 5'h13;
   localparam logic [4:0] KEY_BKSP     = 5'h16;
   localparam logic [4:0] KEY_ACLR     = 5'h17;
   localparam int         MAX_OPERANDS = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5
   } op_e;

   typedef enum logic [2:0] {
      ST_ENTRY,
      ST_CLR,
      ST_OPSEL,
      ST_EXEC,
      ST_SHOW
   } state_e;

   // Operation keys occupy 5'h10..5'h15 except 5'h13, which is ENTER.
   function automatic logic is_op_key(input logic [4:0] key);
      logic hit;
      hit = 1'b0;
      if (key[4:3] == 2'b10) begin
         case (key[2:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: hit = 1'b1;
            default:                               hit = 1'b0;
         endcase
      end
      return hit;
   endfunction

endpackage

// File: rtl/calc_entry_reg.sv
// Hex entry register: digit shift-in with full detect, backspace and clear.
module calc_entry_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              shift_en,
   input  logic [3:0]        digit,
   input  logic              bksp_en,
   output logic [DATA_W-1:0] value,
   output logic              full
);

   logic [DATA_W-1:0] value_d, value_q;

   // A digit is only accepted while the top nibble is still empty.
   assign full = value_q[DATA_W-1:DATA_W-4] != 4'd0;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (shift_en && !full) begin
         value_d = {value_q[DATA_W-5:0], digit};
      end else if (bksp_en) begin
         value_d = value_q >> 4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/calc_input_sequencer.sv
// Keypad-to-ALU sequencer: collects operands and an op, folds them through a handshaked ALU.
// Define CALC_BACKSPACE_EN to enable the BKSP key in ENTRY.
module calc_input_sequencer
   import calc_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int NUM_OPERANDS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        key_val,
   input  logic              key_valid,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   output logic              alu_req,
   input  logic              alu_ack,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_overflow,
   output logic [DATA_W-1:0] display_value,
   output logic [1:0]        operand_idx,
   output logic              result_valid,
   output logic              overflow_flag,
   output logic              busy
);

   localparam logic [1:0] LAST_IDX = 2'(NUM_OPERANDS - 1);

   state_e            state_q, state_d;
   logic [1:0]        k_q, k_d;
   logic [1:0]        idx_q, idx_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              from_show_q, from_show_d;
   logic [DATA_W-1:0] operand_q [MAX_OPERANDS];
   logic [DATA_W-1:0] operand_d [MAX_OPERANDS];

   logic              key_digit, key_enter, key_op, key_aclr, key_bksp;
   logic              e_clr, e_shift, e_bksp, e_full;
   logic [DATA_W-1:0] e_value;

   assign key_digit = key_valid && !key_val[4];
   assign key_enter = key_valid && (key_val == KEY_ENTER);
   assign key_op    = key_valid && is_op_key(key_val);
   assign key_aclr  = key_valid && (key_val == KEY_ACLR);
`ifdef CALC_BACKSPACE_EN
   assign key_bksp  = key_valid && (key_val == KEY_BKSP);
`else
   assign key_bksp  = 1'b0;
`endif

   calc_entry_reg #(
      .DATA_W (DATA_W)
   ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (e_clr),
      .shift_en (e_shift),
      .digit    (key_val[3:0]),
      .bksp_en  (e_bksp),
      .value    (e_value),
      .full     (e_full)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      idx_d       = idx_q;
      op_d        = op_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      from_show_d = from_show_q;
      operand_d   = operand_q;
      e_clr       = 1'b0;
      e_shift     = 1'b0;
      e_bksp      = 1'b0;

      // All-clear wins over everything except an ALU fold in flight.
      if (key_aclr && state_q != ST_EXEC) begin
         state_d     = ST_ENTRY;
         k_d         = '0;
         idx_d       = '0;
         op_d        = '0;
         acc_d       = '0;
         ovf_d       = 1'b0;
         from_show_d = 1'b0;
         e_clr       = 1'b1;
         for (int i = 0; i < MAX_OPERANDS; i++) begin
            operand_d[i] = '0;
         end
      end else begin
         case (state_q)
            ST_ENTRY: begin
               if (key_enter) begin
                  operand_d[k_q] = e_value;
                  from_show_d    = 1'b0;
                  state_d        = ST_CLR;
               end else if (key_digit) begin
                  e_shift = !e_full;
               end else begin
                  e_bksp = key_bksp;
               end
            end
            ST_CLR: begin
               e_clr = 1'b1;
               if (k_q < LAST_IDX) begin
                  k_d     = k_q + 2'd1;
                  state_d = ST_ENTRY;
               end else if (!from_show_q) begin
                  state_d = ST_OPSEL;
               end else begin
                  k_d     = '0;
                  state_d = ST_ENTRY;
               end
            end
            ST_OPSEL: begin
               if (key_op) begin
                  op_d = key_val[2:0];
               end else if (key_enter) begin
                  acc_d   = operand_q[0];
                  idx_d   = 2'd1;
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (alu_ack) begin
                  acc_d = alu_result;
                  ovf_d = ovf_q | alu_overflow;
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_SHOW;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end
            end
            ST_SHOW: begin
               if (key_enter) begin
                  ovf_d       = 1'b0;
                  from_show_d = 1'b1;
                  state_d     = ST_CLR;
               end
            end
            default: state_d = ST_ENTRY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_ENTRY;
         k_q         <= '0;
         idx_q       <= '0;
         op_q        <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         from_show_q <= 1'b0;
         for (int i = 0; i < MAX_OPERANDS; i++) begin
            operand_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         idx_q       <= idx_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         from_show_q <= from_show_d;
         operand_q   <= operand_d;
      end
   end

   always_comb begin
      display_value = e_value;
      case (state_q)
         ST_OPSEL: display_value = {{(DATA_W-3){1'b0}}, op_q};
         ST_SHOW:  display_value = acc_q;
         default:  display_value = e_value;
      endcase
   end

   assign busy          = (state_q == ST_EXEC);
   assign alu_req       = busy;
   assign alu_a         = busy ? acc_q : '0;
   assign alu_b         = busy ? operand_q[idx_q] : '0;
   assign alu_op        = op_q;
   assign result_valid  = (state_q == ST_SHOW);
   assign overflow_flag = ovf_q;
   assign operand_idx   = (state_q == ST_EXEC || state_q == ST_SHOW) ? idx_q : k_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: a 2-operand and a 3-operand instance driven by a model ALU.
module tb_calc_input_sequencer;

   localparam int         W       = 16;
   localparam logic [4:0] K_ENTER = 5'h13;
   localparam logic [4:0] K_BKSP  = 5'h16;
   localparam logic [4:0] K_ACLR  = 5'h17;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic         rst_n_2, key_valid_2, alu_req_2, alu_ack_2, alu_overflow_2;
   logic         result_valid_2, overflow_flag_2, busy_2;
   logic [4:0]   key_val_2;
   logic [W-1:0] alu_a_2, alu_b_2, alu_result_2, display_value_2;
   logic [2:0]   alu_op_2;
   logic [1:0]   operand_idx_2;

   logic         rst_n_3, key_valid_3, alu_req_3, alu_ack_3, alu_overflow_3;
   logic         result_valid_3, overflow_flag_3, busy_3;
   logic [4:0]   key_val_3;
   logic [W-1:0] alu_a_3, alu_b_3, alu_result_3, display_value_3;
   logic [2:0]   alu_op_3;
   logic [1:0]   operand_idx_3;

   int ack_delay_2 = 0, ack_delay_3 = 0;
   int wcnt_2 = 0, wcnt_3 = 0;

   typedef struct packed {
      logic [W-1:0] disp;
      logic [1:0]   idx;
      logic         rv;
      logic         ovf;
      logic         busy;
      logic         req;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } obs_t;

   typedef struct {
      logic [4:0]   key;
      logic [W-1:0] exp_disp;
   } vec_t;

   vec_t         vecs [15];
   logic [W-1:0] cur_ops [4];
   logic [4:0]   opkeys [5];

   // External ALU behaviour: {overflow, result}; carry for add, borrow for sub.
   function automatic logic [W:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] wide;
      wide = '0;
      case (op)
         3'd0: wide = {1'b0, a} + {1'b0, b};
         3'd1: wide = {(b > a), a - b};
         3'd2: wide = {1'b0, a & b};
         3'd4: wide = {1'b0, a | b};
         3'd5: wide = {1'b0, a ^ b};
         default: wide = '0;
      endcase
      return wide;
   endfunction

   assign {alu_overflow_2, alu_result_2} = alu_fn(alu_op_2, alu_a_2, alu_b_2);
   assign {alu_overflow_3, alu_result_3} = alu_fn(alu_op_3, alu_a_3, alu_b_3);

   // A delay of 0 ties ack high; otherwise ack arrives after that many wait cycles per request.
   assign alu_ack_2 = (ack_delay_2 == 0) || (alu_req_2 && wcnt_2 >= ack_delay_2);
   assign alu_ack_3 = (ack_delay_3 == 0) || (alu_req_3 && wcnt_3 >= ack_delay_3);

   always @(posedge clk) begin
      if (!alu_req_2 || alu_ack_2) wcnt_2 <= 0; else wcnt_2 <= wcnt_2 + 1;
      if (!alu_req_3 || alu_ack_3) wcnt_3 <= 0; else wcnt_3 <= wcnt_3 + 1;
   end

   calc_input_sequencer #(.DATA_W(W), .NUM_OPERANDS(2)) dut2 (
      .clk(clk), .rst_n(rst_n_2), .key_val(key_val_2), .key_valid(key_valid_2),
      .alu_a(alu_a_2), .alu_b(alu_b_2), .alu_op(alu_op_2), .alu_req(alu_req_2),
      .alu_ack(alu_ack_2), .alu_result(alu_result_2), .alu_overflow(alu_overflow_2),
      .display_value(display_value_2), .operand_idx(operand_idx_2),
      .result_valid(result_valid_2), .overflow_flag(overflow_flag_2), .busy(busy_2)
   );

   calc_input_sequencer #(.DATA_W(W), .NUM_OPERANDS(3)) dut3 (
      .clk(clk), .rst_n(rst_n_3), .key_val(key_val_3), .key_valid(key_valid_3),
      .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_op(alu_op_3), .alu_req(alu_req_3),
      .alu_ack(alu_ack_3), .alu_result(alu_result_3), .alu_overflow(alu_overflow_3),
      .display_value(display_value_3), .operand_idx(operand_idx_3),
      .result_valid(result_valid_3), .overflow_flag(overflow_flag_3), .busy(busy_3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic obs_t snap(input int sel);
      obs_t o;
      if (sel == 2)
         o = '{display_value_2, operand_idx_2, result_valid_2, overflow_flag_2, busy_2, alu_req_2, alu_a_2, alu_b_2};
      else
         o = '{display_value_3, operand_idx_3, result_valid_3, overflow_flag_3, busy_3, alu_req_3, alu_a_3, alu_b_3};
      return o;
   endfunction

   task automatic drive_key(input int sel, input logic [4:0] k, input logic v);
      if (sel == 2) begin key_val_2 = k; key_valid_2 = v; end
      else          begin key_val_3 = k; key_valid_3 = v; end
   endtask

   // One-cycle key strobe; returns at the falling edge after it was sampled.
   task automatic press(input int sel, input logic [4:0] k);
      @(negedge clk);
      drive_key(sel, k, 1'b1);
      @(negedge clk);
      drive_key(sel, k, 1'b0);
   endtask

   task automatic check_idle(input int sel, input string tag);
      obs_t o;
      o = snap(sel);
      check({tag, "_disp"}, o.disp, 0);
      check({tag, "_idx"},  o.idx,  0);
      check({tag, "_rv"},   o.rv,   0);
      check({tag, "_ovf"},  o.ovf,  0);
      check({tag, "_busy"}, o.busy, 0);
      check({tag, "_req"},  o.req,  0);
      check({tag, "_a"},    o.a,    0);
      check({tag, "_b"},    o.b,    0);
   endtask

   // Clears, enters n operands as four hex digits each, selects the op, and starts the fold.
   task automatic load_calc(input int sel, input int n, input logic [4:0] opkey);
      logic [W-1:0] exp_op;
      press(sel, K_ACLR);
      for (int i = 0; i < n; i++) begin
         for (int j = 3; j >= 0; j--) press(sel, {1'b0, cur_ops[i][4*j +: 4]});
         press(sel, K_ENTER);
      end
      press(sel, opkey);
      exp_op = '0;
      exp_op[2:0] = opkey[2:0];
      check("opsel_disp", snap(sel).disp, exp_op);
      press(sel, K_ENTER);
   endtask

   // Follows EXEC against a fold of cur_ops computed here, then checks the SHOW result.
   task automatic wait_fold(input int sel, input int n, input logic [2:0] opc, input int d, input bit aclr_mid);
      logic [W-1:0] part [5];
      logic [W:0]   r;
      logic         exp_ovf;
      obs_t         o;
      int           cyc, exp_i;
      for (int i = 0; i < 5; i++) part[i] = '0;
      part[1] = cur_ops[0];
      exp_ovf = 1'b0;
      for (int i = 1; i < n; i++) begin
         r = alu_fn(opc, part[i], cur_ops[i]);
         exp_ovf = exp_ovf | r[W];
         part[i+1] = r[W-1:0];
      end
      cyc = 0;
      o = snap(sel);
      while (o.busy && cyc < 100) begin
         exp_i = 1 + cyc / (d + 1);
         if (exp_i > n - 1) exp_i = n - 1;
         check("exec_req", o.req, 1);
         check("exec_idx", o.idx, exp_i);
         check("exec_a", o.a, part[exp_i]);
         check("exec_b", o.b, cur_ops[exp_i]);
         drive_key(sel, aclr_mid && cyc == 0 ? K_ACLR : 5'h0, aclr_mid && cyc == 0);
         @(negedge clk);
         cyc++;
         o = snap(sel);
      end
      drive_key(sel, 5'h0, 1'b0);
      check("exec_cycles", cyc, (n - 1) * (d + 1));
      check("show_valid", o.rv, 1);
      check("show_req", o.req, 0);
      check("show_result", o.disp, part[n]);
      check("show_ovf", o.ovf, exp_ovf);
   endtask

   task automatic leave_show(input int sel);
      press(sel, K_ENTER);
      @(negedge clk);
      check("after_show_ovf", snap(sel).ovf, 0);
      check("after_show_idx", snap(sel).idx, 0);
      check("after_show_rv", snap(sel).rv, 0);
      check("after_show_disp", snap(sel).disp, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      obs_t o;
      rst_n_2 = 1'b0; rst_n_3 = 1'b0;
      key_val_2 = '0; key_val_3 = '0; key_valid_2 = 1'b0; key_valid_3 = 1'b0;
      opkeys = '{5'h10, 5'h11, 5'h12, 5'h14, 5'h15};
      repeat (2) @(negedge clk);
      check_idle(2, "reset2");
      check_idle(3, "reset3");
      rst_n_2 = 1'b1; rst_n_3 = 1'b1;

      // Entry register behaviour: full detect, ignored commands, backspace.
      vecs[0]  = '{K_ACLR, 16'h0000};
      vecs[1]  = '{5'h01,  16'h0001};
      vecs[2]  = '{5'h02,  16'h0012};
      vecs[3]  = '{5'h03,  16'h0123};
      vecs[4]  = '{5'h04,  16'h1234};
      vecs[5]  = '{5'h05,  16'h1234};
      vecs[6]  = '{5'h10,  16'h1234};
      vecs[7]  = '{5'h18,  16'h1234};
`ifdef CALC_BACKSPACE_EN
      vecs[8]  = '{K_BKSP, 16'h0123};
      vecs[9]  = '{5'h09,  16'h1239};
`else
      vecs[8]  = '{K_BKSP, 16'h1234};
      vecs[9]  = '{5'h09,  16'h1234};
`endif
      vecs[10] = '{K_ACLR, 16'h0000};
      vecs[11] = '{5'h07,  16'h0007};
      vecs[12] = '{5'h08,  16'h0078};
`ifdef CALC_BACKSPACE_EN
      vecs[13] = '{K_BKSP, 16'h0007};
`else
      vecs[13] = '{K_BKSP, 16'h0078};
`endif
      vecs[14] = '{5'h0F,  16'h007F};
`ifdef CALC_BACKSPACE_EN
      vecs[14].exp_disp = 16'h007F;
`else
      vecs[14].exp_disp = 16'h078F;
`endif
      for (int i = 0; i < 15; i++) begin
         press(2, vecs[i].key);
         check($sformatf("vec%0d_disp", i), snap(2).disp, vecs[i].exp_disp);
         check($sformatf("vec%0d_idx", i), snap(2).idx, 0);
      end

      // Basic add with ack tied high: keys 1,2,A,ENTER,3,ENTER,op,ENTER.
      ack_delay_2 = 0;
      press(2, K_ACLR);
      press(2, 5'h01); press(2, 5'h02); press(2, 5'h0A);
      check("entry_012a", snap(2).disp, 16'h012A);
      press(2, K_ENTER);
      @(negedge clk);
      check("k_after_first", snap(2).idx, 1);
      check("disp_after_clr", snap(2).disp, 0);
      press(2, 5'h03); press(2, K_ENTER);
      press(2, 5'h14);
      check("opsel_or", snap(2).disp, 16'h0004);
      press(2, 5'h07);
      check("opsel_digit_ignored", snap(2).disp, 16'h0004);
      press(2, 5'h10);
      check("opsel_add", snap(2).disp, 16'h0000);
      press(2, K_ENTER);
      cur_ops = '{16'h012A, 16'h0003, 16'h0000, 16'h0000};
      wait_fold(2, 2, 3'd0, 0, 1'b0);
      check("basic_result", snap(2).disp, 16'h012D);
      leave_show(2);

      // ACLR in OPSEL clears the op and operands.
      press(2, 5'h05); press(2, K_ENTER); press(2, 5'h06); press(2, K_ENTER);
      press(2, 5'h15);
      check("opsel_xor", snap(2).disp, 16'h0005);
      press(2, K_ACLR);
      check("aclr_disp", snap(2).disp, 0);
      check("aclr_idx", snap(2).idx, 0);
      check("aclr_rv", snap(2).rv, 0);
      press(2, K_ENTER); press(2, K_ENTER);
      check("aclr_op_cleared", snap(2).disp, 0);
      press(2, K_ENTER);
      cur_ops = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      wait_fold(2, 2, 3'd0, 0, 1'b0);
      leave_show(2);

      // Three-operand fold, two wait cycles per request, overflow only on the first step.
      ack_delay_3 = 2;
      cur_ops = '{16'hFFFF, 16'h0002, 16'h0003, 16'h0000};
      load_calc(3, 3, 5'h10);
      wait_fold(3, 3, 3'd0, 2, 1'b0);
      check("n3_result", snap(3).disp, 16'h0004);
      check("n3_ovf_sticky", snap(3).ovf, 1);
      leave_show(3);

      // ACLR during EXEC is dropped.
      ack_delay_3 = 3;
      cur_ops = '{16'h0001, 16'h0002, 16'h0003, 16'h0000};
      load_calc(3, 3, 5'h10);
      wait_fold(3, 3, 3'd0, 3, 1'b1);
      check("aclr_exec_result", snap(3).disp, 16'h0006);
      leave_show(3);

      // Randomised calculations on both instances.
      for (int it = 0; it < 10; it++) begin
         int sel, n, d;
         logic [4:0] ok;
         sel = (it % 2 == 0) ? 2 : 3;
         n   = sel;
         d   = $urandom_range(0, 3);
         ok  = opkeys[$urandom_range(0, 4)];
         for (int i = 0; i < 4; i++) cur_ops[i] = W'($urandom());
         if (sel == 2) ack_delay_2 = d; else ack_delay_3 = d;
         load_calc(sel, n, ok);
         wait_fold(sel, n, ok[2:0], d, 1'b0);
         leave_show(sel);
      end

      // Reset in the middle of EXEC aborts the fold; a late ack is ignored.
      ack_delay_3 = 4;
      cur_ops = '{16'h0011, 16'h0022, 16'h0033, 16'h0000};
      load_calc(3, 3, 5'h10);
      o = snap(3);
      check("pre_reset_busy", o.busy, 1);
      rst_n_3 = 1'b0;
      @(negedge clk);
      check_idle(3, "mid_reset");
      ack_delay_3 = 0;
      rst_n_3 = 1'b1;
      repeat (2) @(negedge clk);
      check_idle(3, "late_ack");
      press(3, 5'h09);
      check("post_reset_entry", snap(3).disp, 16'h0009);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
